// File: rtl/mult_div_unit_if.sv
// Issue/result channel of the RV32M unit: issue side (valid/ready) and CDB side (valid/ready).
interface mult_div_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       func;
  logic [XLEN-1:0]  opa;
  logic [XLEN-1:0]  opb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_value;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, func, opa, opb, in_tag, out_ready,
    input  in_ready, out_valid, out_value, out_tag
  );

  modport slave (
    input  in_valid, func, opa, opb, in_tag, out_ready,
    output in_ready, out_valid, out_value, out_tag
  );
endinterface

// File: rtl/mult_div_unit.sv
// RV32M unit: MUL_STAGES-deep multiply pipe, XLEN+1-cycle radix-2 divider; stalls whole mul pipe / holds DONE under CDB backpressure.
// Optional DIV_EARLY_OUT_EN: div-by-zero, signed overflow and divide-by-one skip the iterative steps (result next cycle).
module mult_div_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3,
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  mult_div_unit_if.slave   io
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       div_state;
  logic             div_done;
  logic             div_drain;
  logic             mul_last_vld;
  logic             mul_drain;
  logic             mul_stall;
  logic             accept;
  logic             accept_mul;
  logic             accept_div;

  // Divider owns the port whenever it is DONE; the mul pipe only drains behind it.
  assign div_done    = (div_state == DIV_DONE);
  assign div_drain   = div_done & io.out_ready;
  assign mul_drain   = io.out_ready & ~div_done;
  assign mul_stall   = mul_last_vld & ~mul_drain;
  assign io.in_ready = io.func[2] ? (div_state == DIV_IDLE) : ~mul_stall;
  assign accept      = io.in_valid & io.in_ready & ~flush;
  assign accept_mul  = accept & ~io.func[2];
  assign accept_div  = accept & io.func[2];

  logic                a_signed;
  logic                b_signed;
  logic [2*XLEN-1:0]   a_ext;
  logic [2*XLEN-1:0]   b_ext;
  logic [2*XLEN-1:0]   product;
  logic [XLEN-1:0]     mul_sel;

  always_comb begin
    a_signed = (io.func[1:0] != 2'b11);
    b_signed = ~io.func[1];
    a_ext    = {{XLEN{a_signed & io.opa[XLEN-1]}}, io.opa};
    b_ext    = {{XLEN{b_signed & io.opb[XLEN-1]}}, io.opb};
    product  = a_ext * b_ext;
    mul_sel  = (io.func[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  logic             mul_vld [MUL_STAGES];
  logic [TAG_W-1:0] mul_tag [MUL_STAGES];
  logic [XLEN-1:0]  mul_val [MUL_STAGES];

  assign mul_last_vld = mul_vld[MUL_STAGES-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < MUL_STAGES; s++) begin
        mul_vld[s] <= 1'b0;
        mul_tag[s] <= '0;
        mul_val[s] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < MUL_STAGES; s++) begin
        mul_vld[s] <= 1'b0;
      end
    end else if (!mul_stall) begin
      mul_vld[0] <= accept_mul;
      mul_tag[0] <= io.in_tag;
      mul_val[0] <= mul_sel;
      for (int s = 1; s < MUL_STAGES; s++) begin
        mul_vld[s] <= mul_vld[s-1];
        mul_tag[s] <= mul_tag[s-1];
        mul_val[s] <= mul_val[s-1];
      end
    end
  end

  logic             in_signed;
  logic             in_a_neg;
  logic             in_b_neg;
  logic             in_zero;
  logic             in_ovf;
  logic [XLEN-1:0]  in_a_mag;
  logic [XLEN-1:0]  in_b_mag;

  always_comb begin
    in_signed = ~io.func[0];
    in_a_neg  = in_signed & io.opa[XLEN-1];
    in_b_neg  = in_signed & io.opb[XLEN-1];
    in_a_mag  = in_a_neg ? (XLEN'(0) - io.opa) : io.opa;
    in_b_mag  = in_b_neg ? (XLEN'(0) - io.opb) : io.opb;
    in_zero   = (io.opb == '0);
    in_ovf    = in_signed & (io.opa == MIN_NEG) & (io.opb == '1);
  end

`ifdef DIV_EARLY_OUT_EN
  logic             in_one;
  logic [XLEN-1:0]  early_res;

  always_comb begin
    in_one = (io.opb == XLEN'(1));
    if (io.func[1]) begin
      early_res = in_zero ? io.opa : '0;
    end else begin
      early_res = in_zero ? '1 : (in_ovf ? MIN_NEG : io.opa);
    end
  end
`endif

  logic [XLEN-1:0]  div_rem;
  logic [XLEN-1:0]  div_quo;
  logic [XLEN-1:0]  div_dvs;
  logic [XLEN-1:0]  div_opa;
  logic [XLEN-1:0]  div_res;
  logic [TAG_W-1:0] div_tag;
  logic [CNT_W-1:0] div_cnt;
  logic             div_q_neg;
  logic             div_r_neg;
  logic             div_sel_rem;
  logic             div_by_zero;
  logic             div_ovf;

  logic [XLEN:0]    step_shift;
  logic [XLEN:0]    step_diff;
  logic [XLEN-1:0]  step_rem;
  logic [XLEN-1:0]  step_quo;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;
  logic [XLEN-1:0]  calc_res;

  // Restoring step: the borrow out of the XLEN+1-bit trial subtract decides the quotient bit.
  always_comb begin
    step_shift = {div_rem, div_quo[XLEN-1]};
    step_diff  = step_shift - {1'b0, div_dvs};
    if (step_diff[XLEN]) begin
      step_rem = step_shift[XLEN-1:0];
      step_quo = {div_quo[XLEN-2:0], 1'b0};
    end else begin
      step_rem = step_diff[XLEN-1:0];
      step_quo = {div_quo[XLEN-2:0], 1'b1};
    end
    q_fix = div_q_neg ? (XLEN'(0) - step_quo) : step_quo;
    r_fix = div_r_neg ? (XLEN'(0) - step_rem) : step_rem;
    if (div_by_zero) begin
      q_fix = '1;
      r_fix = div_opa;
    end else if (div_ovf) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    calc_res = div_sel_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_state   <= DIV_IDLE;
      div_cnt     <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_dvs     <= '0;
      div_opa     <= '0;
      div_res     <= '0;
      div_tag     <= '0;
      div_q_neg   <= 1'b0;
      div_r_neg   <= 1'b0;
      div_sel_rem <= 1'b0;
      div_by_zero <= 1'b0;
      div_ovf     <= 1'b0;
    end else if (flush) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (accept_div) begin
            div_tag     <= io.in_tag;
            div_sel_rem <= io.func[1];
            div_q_neg   <= in_a_neg ^ in_b_neg;
            div_r_neg   <= in_a_neg;
            div_by_zero <= in_zero;
            div_ovf     <= in_ovf;
            div_opa     <= io.opa;
            div_rem     <= '0;
            div_quo     <= in_a_mag;
            div_dvs     <= in_b_mag;
            div_cnt     <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (in_zero | in_ovf | in_one) begin
              div_res   <= early_res;
              div_state <= DIV_DONE;
            end else begin
              div_state <= DIV_CALC;
            end
`else
            div_state   <= DIV_CALC;
`endif
          end
        end
        DIV_CALC: begin
          div_rem <= step_rem;
          div_quo <= step_quo;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CNT_W'(XLEN - 1)) begin
            div_res   <= calc_res;
            div_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (div_drain) begin
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  assign io.out_valid = div_done | mul_last_vld;
  assign io.out_value = div_done ? div_res : mul_val[MUL_STAGES-1];
  assign io.out_tag   = div_done ? div_tag : mul_tag[MUL_STAGES-1];

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed timing/arbitration/flush/reset cases plus randomized ops vs an arithmetic model.
module tb_mult_div_unit;
  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 3;
  localparam int TAG_W      = 5;
  localparam int DIV_LAT    = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = XLEN + 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_iss = 0;
  int   n_rx  = 0;
  bit   rand_rdy = 1'b0;
  bit   rnd_mode = 1'b0;

  logic [31:0] exp_val [32];
  bit          exp_pend [32];
  logic [31:0] got_val [$];
  logic [4:0]  got_tag [$];
  int          got_cyc [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mult_div_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mult_div_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  always @(negedge clock) begin
    if (reset && !flush && bus.out_valid && bus.out_ready) begin
      got_val.push_back(bus.out_value);
      got_tag.push_back(bus.out_tag);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RV32M semantics straight from the ISA definition.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic drain_check();
    logic [31:0] v;
    logic [4:0]  t;
    while (got_val.size() > 0) begin
      v = got_val.pop_front();
      t = got_tag.pop_front();
      void'(got_cyc.pop_front());
      chk("rand_tag_pending", 64'(exp_pend[t]), 64'd1);
      chk("rand_value", v, exp_val[t]);
      exp_pend[t] = 1'b0;
      n_rx++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    if (rnd_mode) drain_check();
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output int acc_cyc);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.func     = f;
    bus.opa      = a;
    bus.opb      = b;
    bus.in_tag   = t;
    #1;
    while (!bus.in_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!bus.in_ready) chk("issue_ready_timeout", 64'(bus.in_ready), 64'd1);
    acc_cyc = cyc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w;
    w = 0;
    while (got_val.size() < n && w < 100) begin
      step();
      w++;
    end
    if (got_val.size() < n) chk("out_timeout", 64'(got_val.size()), 64'(n));
  endtask

  task automatic clear_got();
    got_val.delete();
    got_tag.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [2:0]  f4 [4];
    logic [31:0] a4 [4];
    logic [31:0] b4 [4];
    int          acc [4];
    int          t0, t1;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rt;

    bus.in_valid  = 1'b0;
    bus.func      = 3'd0;
    bus.opa       = '0;
    bus.opb       = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_pend[i] = 1'b0;
      exp_val[i]  = '0;
    end

    // Reset state
    repeat (3) step();
    reset = 1'b1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_value", 64'(bus.out_value), 64'd0);
    chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
    chk("rst_in_ready_mul", 64'(bus.in_ready), 64'd1);
    bus.func = 3'd4;
    #1;
    chk("rst_in_ready_div", 64'(bus.in_ready), 64'd1);

    // Back-to-back multiplies
    bus.out_ready = 1'b1;
    f4 = '{3'd0, 3'd1, 3'd3, 3'd2};
    a4 = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    b4 = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd2};
    for (int i = 0; i < 4; i++) issue(f4[i], a4[i], b4[i], 5'(i + 1), acc[i]);
    for (int i = 1; i < 4; i++) chk("mul_b2b_accept", 64'(acc[i]), 64'(acc[0] + i));
    wait_out(4);
    for (int i = 0; i < 4 && got_val.size() > 0; i++) begin
      chk("mul_value", got_val.pop_front(), ref_op(f4[i], a4[i], b4[i]));
      chk("mul_tag", 64'(got_tag.pop_front()), 64'(i + 1));
      chk("mul_latency", 64'(got_cyc.pop_front()), 64'(acc[i] + MUL_STAGES));
    end
    clear_got();

    // Signed divide with a multiply slipped in while the divider is busy
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, t0);
    bus.func = 3'd4;
    #1;
    chk("div_busy_in_ready", 64'(bus.in_ready), 64'd0);
    issue(3'd0, 32'd3, 32'd4, 5'd7, t1);
    chk("mul_during_div_accept", 64'(t1), 64'(t0 + 1));
    wait_out(2);
    if (got_val.size() == 2) begin
      chk("mul_during_div_value", got_val[0], 32'd12);
      chk("mul_during_div_cycle", 64'(got_cyc[0]), 64'(t1 + MUL_STAGES));
      chk("div_neg_value", got_val[1], ref_op(3'd4, 32'hFFFF_FFF9, 32'd2));
      chk("div_latency", 64'(got_cyc[1]), 64'(t0 + DIV_LAT));
    end
    clear_got();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, t0);
    wait_out(1);
    if (got_val.size() == 1) begin
      chk("rem_neg_value", got_val[0], ref_op(3'd6, 32'hFFFF_FFF9, 32'd2));
      chk("rem_latency", 64'(got_cyc[0]), 64'(t0 + DIV_LAT));
    end
    clear_got();

    // Divider special cases
    f4 = '{3'd4, 3'd7, 3'd4, 3'd6};
    a4 = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    b4 = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(f4[i], a4[i], b4[i], 5'(9 + i), t0);
      wait_out(1);
      if (got_val.size() == 1) begin
        chk("div_special_value", got_val[0], ref_op(f4[i], a4[i], b4[i]));
        chk("div_special_latency", 64'(got_cyc[0]), 64'(t0 + SPECIAL_LAT));
      end
      clear_got();
    end

    // Divider and multiply collide on the port under backpressure
    bus.out_ready = 1'b0;
    issue(3'd4, 32'd100, 32'd7, 5'd20, t0);
    repeat (29) step();
    issue(3'd0, 32'd6, 32'd7, 5'd21, t1);
    chk("arb_mul_accept", 64'(t1), 64'(t0 + DIV_LAT - MUL_STAGES));
    repeat (2) step();
    chk("arb_out_valid", 64'(bus.out_valid), 64'd1);
    chk("arb_div_first_tag", 64'(bus.out_tag), 64'd20);
    step();
    chk("arb_hold_value", 64'(bus.out_value), 64'd14);
    bus.func = 3'd0;
    #1;
    chk("arb_mul_stall_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.out_ready = 1'b1;
    wait_out(2);
    if (got_val.size() == 2) begin
      chk("arb_first_tag", 64'(got_tag[0]), 64'd20);
      chk("arb_first_value", got_val[0], 32'd14);
      chk("arb_first_cycle", 64'(got_cyc[0]), 64'(t0 + DIV_LAT + 2));
      chk("arb_second_tag", 64'(got_tag[1]), 64'd21);
      chk("arb_second_value", got_val[1], 32'd42);
      chk("arb_second_cycle", 64'(got_cyc[1]), 64'(t0 + DIV_LAT + 3));
    end
    clear_got();

    // Flush kills divider, mul pipe and the coincident request
    issue(3'd4, 32'd1000, 32'd3, 5'd12, t0);
    issue(3'd0, 32'd5, 32'd5, 5'd13, t1);
    bus.in_valid = 1'b1;
    bus.func     = 3'd0;
    bus.opa      = 32'd9;
    bus.opb      = 32'd9;
    bus.in_tag   = 5'd14;
    flush        = 1'b1;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.func     = 3'd4;
    #1;
    chk("flush_div_idle_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (40) step();
    chk("flush_no_output", 64'(got_val.size()), 64'd0);
    clear_got();

    // Reset in the middle of a divide
    issue(3'd5, 32'd1000, 32'd3, 5'd15, t0);
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.func = 3'd4;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_value", 64'(bus.out_value), 64'd0);
    chk("midrst_out_tag",   64'(bus.out_tag),   64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (40) step();
    chk("midrst_no_output", 64'(got_val.size()), 64'd0);
    clear_got();

    // Randomized mix with random CDB grants
    rnd_mode = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(2, 9));
        default: rb = $urandom;
      endcase
      rt = 5'(i % 32);
      exp_val[rt]  = ref_op(rf, ra, rb);
      exp_pend[rt] = 1'b1;
      issue(rf, ra, rb, rt, t0);
      n_iss++;
    end
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 200 && n_rx < n_iss; w++) step();
    chk("rand_result_count", 64'(n_rx), 64'(n_iss));
    rnd_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Pipelined RV32M execution unit that succeeds the single-cycle combinational ALU multiply path. It accepts issued multiply/divide operations from the reservation-station issue port and executes multiplies in a parametrised-depth pipeline. Divides and remainders run in an iterative radix-2 FSM, and each result returns on one CDB-style output port under a valid/ready handshake. It sits beside the ALU and address-calculation units in the execute stage.

## Interface
- XLEN, 32, operand/result width
- MUL_STAGES, 3, multiply latency in cycles (≥1)
- TAG_W, 5, ROB tag width
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- flush  in  1  squash all in-flight work (branch mispredict)
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept `func` this cycle
- func  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opa, opb  in  XLEN  rs1/rs2 values
- in_tag  in  TAG_W  destination ROB tag
- out_valid  out  1  result available
- out_ready  in  1  CDB grant
- out_value  out  XLEN  result
- out_tag  out  TAG_W  ROB tag of result

## Operation
- Accept = in_valid & in_ready & ~flush. in_ready depends on func[2]:
  - func[2]=0: in_ready = ~mul_stall.
  - func[2]=1: in_ready = (div_state==IDLE).
- Multiply pipeline: MUL_STAGES valid/tag/value stages. Stage 0 computes the full 2·XLEN product, sign-extending per func: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned. It selects the low XLEN bits for MUL, high XLEN bits otherwise.
- mul_stall = last-stage valid & ~mul_drain. When stalled, every stage holds; bubbles are not collapsed.
- Divider FSM:
  - IDLE → CALC on accept. Latch the operand magnitudes for signed ops, the quotient/remainder sign flags, the tag, and the quotient/remainder select.
  - CALC: one restoring shift-subtract step per cycle. Counter width $clog2(XLEN+1). After XLEN steps, apply sign correction and go to DONE.
  - DONE: holds the result until drained, then returns to IDLE.
- Special cases (RISC-V defined):
  - Divide by zero: quotient = all ones, remainder = opa.
  - Signed overflow (opa=0x8000_0000, opb=−1): quotient = 0x8000_0000, remainder = 0.
- Output arbitration:
  - out_valid = div DONE | mul last-stage valid.
  - When both are valid, the divider is presented first.
  - div_drain = DONE & out_ready. mul_drain = out_ready & ~(div DONE).
- flush: in the same cycle, clears all mul stage valids, forces the divider to IDLE, and drops any coincident input. The next cycle sees out_valid=0.
- Reset (reset=0 at posedge): all valids 0, div_state IDLE, counter 0, all result/tag registers 0. After reset, out_valid=0, out_value=0, out_tag=0, and in_ready=1.

## Timing
- MUL accepted at cycle T: out_valid at T+MUL_STAGES if unstalled. Throughput 1 per cycle.
- DIV accepted at T: CALC during T+1…T+XLEN, out_valid at T+XLEN+1 (33 for XLEN=32). One divide in flight at a time.
- The output is registered: out_value and out_tag are stable while out_valid=1 and out_ready=0.
- reset takes priority over flush; flush takes priority over accept and drain.
- A divide may be accepted in the same cycle a DONE result drains only if div_state is IDLE. No bypass exists: the earliest re-accept is the cycle after the drain.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: divide-by-zero, signed overflow, and opb==1 skip CALC. IDLE → DONE directly, so out_valid is at T+1.
  - Undefined: every divide takes the full XLEN+1 cycles. Special-case results are still produced (selected in the final CALC step).

## Test plan
- MUL 7×−3, then MULH 0x8000_0000×0x8000_0000, MULHU 0xFFFF_FFFF×2, MULHSU −1×2, all back-to-back with out_ready=1 → four results at T+3…T+6: 0xFFFF_FFEB, 0x4000_0000, 0x0000_0001, 0xFFFF_FFFF; in_ready stays 1.
- DIV −7/2 and REM −7/2 (sequential) → 0xFFFF_FFFD and 0xFFFF_FFFF, each at T+33; in_ready=0 for DIV during the busy cycles; MUL is still accepted meanwhile.
- DIV 5/0 → 0xFFFF_FFFF; REMU 5/0 → 5; DIV 0x8000_0000/−1 → 0x8000_0000. Latency is T+1 with DIV_EARLY_OUT_EN, T+33 without.
- Divider DONE and MUL last stage valid simultaneously, out_ready held 0 for 2 cycles, then 1 → divider result first, MUL second; MUL pipe and in_ready(mul)=0 hold during the stall.
- Issue DIV and 2 MULs, assert flush at T+2 with in_valid=1 → no out_valid thereafter; divider IDLE and in_ready=1 at T+3.
- reset=0 mid-CALC for 1 cycle → out_valid=0, out_value=0, out_tag=0, in_ready=1 the next cycle.
